// File: rtl/alu_pkg.sv
// Shared ALU definitions: functional-unit codes (matching the function decoder's
// alu_fun encoding) and the default result width.
package alu_pkg;
  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;

  localparam int DEFAULT_OUT_WIDTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read. A push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end
endmodule

// File: rtl/alu_result_encoder.sv
// Encodes the one-hot unit-valid flags into a unit code, buffers {code, result}
// and presents it over valid/ready with multi-hot and overflow error reporting.
module alu_result_encoder
  import alu_pkg::*;
#(
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH,
  parameter int DEPTH     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [OUT_WIDTH-1:0] arith_out,
  input  logic                 arith_flag,
  input  logic [OUT_WIDTH-1:0] logic_out,
  input  logic                 logic_flag,
  input  logic [OUT_WIDTH-1:0] cmp_out,
  input  logic                 cmp_flag,
  input  logic [OUT_WIDTH-1:0] shift_out,
  input  logic                 shift_flag,
  input  logic                 out_ready,
  input  logic                 clr_err,
  output logic [OUT_WIDTH-1:0] alu_out,
  output logic [1:0]           unit_id,
  output logic                 out_valid,
  output logic                 fifo_full,
  output logic                 multi_hot_err,
  output logic                 overflow_err
);
  logic [3:0]             flags;
  logic [1:0]             sel_id;
  logic [OUT_WIDTH-1:0]   sel_data;
  logic                   push, pop, multi_hot, overflow;
  logic                   full, empty;
  logic [OUT_WIDTH+1:0]   head;
  logic                   multi_hot_err_q, multi_hot_err_d;
  logic                   overflow_err_q, overflow_err_d;

  assign flags = {shift_flag, cmp_flag, logic_flag, arith_flag};

  always_comb begin
    sel_id   = UNIT_ARITH;
    sel_data = '0;
    if (arith_flag) begin
      sel_id   = UNIT_ARITH;
      sel_data = arith_out;
    end else if (logic_flag) begin
      sel_id   = UNIT_LOGIC;
      sel_data = logic_out;
    end else if (cmp_flag) begin
      sel_id   = UNIT_CMP;
      sel_data = cmp_out;
    end else if (shift_flag) begin
      sel_id   = UNIT_SHIFT;
      sel_data = shift_out;
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(flags & (flags - 4'd1));
  assign push      = |flags;
  assign out_valid = !empty;
  assign fifo_full = full;
  assign pop       = out_valid && out_ready;
  assign overflow  = push && full && !pop;

  sync_fifo #(
    .WIDTH(OUT_WIDTH + 2),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .srst   (RST),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({sel_id, sel_data}),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    multi_hot_err_d = multi_hot;
    overflow_err_d  = overflow_err_q;
    if (overflow) begin
      overflow_err_d = 1'b1;
    end else if (clr_err) begin
      overflow_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      multi_hot_err_q <= 1'b0;
      overflow_err_q  <= 1'b0;
    end else begin
      multi_hot_err_q <= multi_hot_err_d;
      overflow_err_q  <= overflow_err_d;
    end
  end

  assign alu_out       = out_valid ? head[OUT_WIDTH-1:0] : '0;
  assign unit_id       = out_valid ? head[OUT_WIDTH+1:OUT_WIDTH] : 2'd0;
  assign multi_hot_err = multi_hot_err_q;
  assign overflow_err  = overflow_err_q;
endmodule

// File: tb/tb_alu_result_encoder.sv
// Scoreboard bench for alu_result_encoder: expected entries are queued as flags
// are driven and compared against the head while the DUT presents it.
module tb_alu_result_encoder;
  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        out_ready, clr_err;
  logic [15:0] alu_out;
  logic [1:0]  unit_id;
  logic        out_valid, fifo_full, multi_hot_err, overflow_err;

  alu_result_encoder #(.OUT_WIDTH(16), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .arith_out(arith_out), .arith_flag(arith_flag),
    .logic_out(logic_out), .logic_flag(logic_flag),
    .cmp_out(cmp_out), .cmp_flag(cmp_flag),
    .shift_out(shift_out), .shift_flag(shift_flag),
    .out_ready(out_ready), .clr_err(clr_err),
    .alu_out(alu_out), .unit_id(unit_id), .out_valid(out_valid),
    .fifo_full(fifo_full), .multi_hot_err(multi_hot_err),
    .overflow_err(overflow_err)
  );

  always #5 CLK = ~CLK;

  logic [17:0] sb_q[$];
  logic        exp_multi = 1'b0;
  logic        exp_ovf   = 1'b0;
  int          n_checks  = 0;
  int          n_pass    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: check the outputs for the current cycle, drive new inputs,
  // and advance the reference model. flags = {shift, cmp, logic, arith}.
  task automatic step(input logic [3:0] f, input logic [15:0] a, input logic [15:0] l,
                      input logic [15:0] c, input logic [15:0] s,
                      input logic rdy, input logic clr, input logic rst);
    logic [17:0] ent;
    logic        pop;
    @(negedge CLK);
    check_val("out_valid", out_valid, sb_q.size() != 0);
    check_val("fifo_full", fifo_full, sb_q.size() == 2);
    check_val("multi_hot_err", multi_hot_err, exp_multi);
    check_val("overflow_err", overflow_err, exp_ovf);
    if (sb_q.size() != 0) begin
      check_val("alu_out", alu_out, sb_q[0][15:0]);
      check_val("unit_id", unit_id, sb_q[0][17:16]);
    end else begin
      check_val("alu_out_idle", alu_out, 0);
      check_val("unit_id_idle", unit_id, 0);
    end
    {shift_flag, cmp_flag, logic_flag, arith_flag} = f;
    arith_out = a; logic_out = l; cmp_out = c; shift_out = s;
    out_ready = rdy; clr_err = clr; RST = rst;
    if (rst) begin
      sb_q.delete();
      exp_multi = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      pop = (sb_q.size() != 0) && rdy;
      if (pop) begin
        $display("pop  id=%0d data=%04h (queued %0d)", sb_q[0][17:16], sb_q[0][15:0], sb_q.size());
        void'(sb_q.pop_front());
      end
      exp_multi = ($countones(f) > 1);
      if (f != 4'b0000) begin
        if      (f[0]) ent = {2'd0, a};
        else if (f[1]) ent = {2'd1, l};
        else if (f[2]) ent = {2'd2, c};
        else           ent = {2'd3, s};
        if (sb_q.size() == 2) exp_ovf = 1'b1;
        else sb_q.push_back(ent);
      end else if (clr) begin
        exp_ovf = 1'b0;
      end
      if (f != 4'b0000 && sb_q.size() == 2 && clr && !exp_ovf) exp_ovf = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
    {shift_flag, cmp_flag, logic_flag, arith_flag} = 4'b0;
    arith_out = '0; logic_out = '0; cmp_out = '0; shift_out = '0;
    repeat (2) @(posedge CLK);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);  // reset state checked here

    // Single logic result with ready high: one cycle valid, then idle.
    step(4'b0010, 0, 16'h00A5, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    // Fill, overflow with the FIFO contents untouched, drain, clear.
    step(4'b0001, 16'h0011, 0, 0, 0, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 16'h0033, 0, 0, 0);
    step(4'b0100, 0, 0, 16'h0022, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 1, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    // Overflow and clear in the same cycle: set wins.
    step(4'b0001, 16'h0101, 0, 0, 0, 0, 0, 0);
    step(4'b0001, 16'h0102, 0, 0, 0, 0, 0, 0);
    step(4'b0010, 0, 16'h0103, 0, 0, 0, 1, 0);
    step(4'b0000, 0, 0, 0, 0, 0, 1, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    // Multi-hot: arith wins, pulse lasts one cycle, single entry.
    step(4'b0101, 16'h1234, 0, 16'h5678, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b1110, 0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    // Full with simultaneous pop and push: accepted, order preserved.
    step(4'b0100, 0, 0, 16'h0201, 0, 0, 0, 0);
    step(4'b0010, 0, 16'h0202, 0, 0, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 16'h0203, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    // Back-to-back stream, pointers wrap several times.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h3000 + 16'(i * 17) + 16'($urandom_range(0, 15) << 8);
      step(4'b0001 << (i % 4), d, d ^ 16'h00FF, d ^ 16'h0F00, d ^ 16'hF000, 1, 0, 0);
    end
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    // Reset mid-operation with two entries buffered, errors set, and a flag high.
    step(4'b0001, 16'h0401, 0, 0, 0, 0, 0, 0);
    step(4'b0001, 16'h0402, 0, 0, 0, 0, 0, 0);
    step(4'b0011, 16'h0403, 16'h0404, 0, 0, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 16'h0405, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_result_encoder.md
# alu_result_encoder

Collects results from the four ALU functional units (arithmetic, logic, compare, shift) after the function decoder has enabled exactly one of them. Each unit reports completion on a one-hot valid flag. This block encodes that one-hot flag back into the 2-bit unit code. It also buffers the result with its unit code in a small FIFO and presents it to the system controller over a valid/ready handshake. It sits between the ALU unit outputs and the controller's result path.

## Interface
- OUT_WIDTH, 16, result width of every functional unit
- DEPTH, 2, FIFO entries; power of two, ≥ 2
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- arith_out  in  OUT_WIDTH  arithmetic unit result
- arith_flag  in  1  arithmetic result valid, one-cycle pulse
- logic_out / logic_flag  in  OUT_WIDTH / 1  logic unit result / valid
- cmp_out / cmp_flag  in  OUT_WIDTH / 1  compare unit result / valid
- shift_out / shift_flag  in  OUT_WIDTH / 1  shift unit result / valid
- out_ready  in  1  controller accepts head entry
- clr_err  in  1  clears sticky overflow_err
- alu_out  out  OUT_WIDTH  head result; 0 when out_valid=0
- unit_id  out  2  head unit code (0 arith, 1 logic, 2 cmp, 3 shift); 0 when out_valid=0
- out_valid  out  1  FIFO non-empty
- fifo_full  out  1  count == DEPTH; controller must not issue a new ALU op
- multi_hot_err  out  1  one-cycle pulse: more than one flag was high
- overflow_err  out  1  sticky: a result was dropped

## Operation
- Push condition: any flag high. Encoded id uses fixed priority, arith > logic > cmp > shift. The pushed data is the selected unit's *_out.
- More than one flag high in cycle N:
  - push the priority winner only;
  - multi_hot_err = 1 in cycle N+1 only.
- Pop condition: out_valid && out_ready in the same cycle.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the entry is dropped, overflow_err is set, and the FIFO contents are unchanged.
- Push and pop in the same cycle, not full: count unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- overflow_err:
  - cleared by clr_err;
  - if clr_err and a new overflow occur in the same cycle, overflow_err is set (set wins).
- Reset values: pointers, count, alu_out, unit_id, out_valid, fifo_full, multi_hot_err and overflow_err are all 0. Memory contents don't care.
- RST asserted mid-operation discards all buffered entries. Flags sampled in the reset cycle are ignored.

## Timing
- Flag high in cycle N → entry written at the edge ending cycle N → out_valid = 1 in cycle N+1. There is no combinational bypass.
- alu_out and unit_id are combinational reads of the head entry, gated by out_valid. They stay stable while out_valid=1 and out_ready=0.
- Pop at the edge ending cycle M → next entry, or out_valid = 0, in cycle M+1.
- fifo_full and out_valid are derived from the registered count. Neither depends combinationally on flags or out_ready.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Shared package alu_pkg holds:
  - UNIT_ARITH=2'd0, UNIT_LOGIC=2'd1, UNIT_CMP=2'd2, UNIT_SHIFT=2'd3; these match the function-decoder alu_fun encoding;
  - the default OUT_WIDTH.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) stores {unit_id, result}. It owns the pointers and count, and exposes push, pop, full, empty and head.
- The top level contains:
  - the priority encoder and one-hot check;
  - the multi_hot_err register;
  - the overflow logic;
  - output gating.

## Test plan
- Reset, then logic_flag=1 with logic_out=16'h00A5 in cycle 3, out_ready=1 → cycle 4: out_valid=1, alu_out=16'h00A5, unit_id=1; cycle 5: out_valid=0, alu_out=0.
- out_ready=0; push arith 16'h0011, then shift 16'h0033 → fifo_full=1. Push cmp 16'h0022 → overflow_err=1 and the FIFO still holds 0011/0, 0033/3. Release out_ready → pops in order, then out_valid=0. clr_err → overflow_err=0.
- arith_flag and cmp_flag together, data 16'h1234 / 16'h5678 → entry 16'h1234/id 0; multi_hot_err high for exactly one cycle; no second entry.
- FIFO full with out_ready=1 and a new shift_flag in the same cycle → no overflow; count stays 2; order is preserved.
- Stream 8 results back-to-back with out_ready=1 → one result per cycle, pointers wrap, ids match sources.
- RST for one cycle while 2 entries are buffered and a flag is high → next cycle: out_valid=0, fifo_full=0, both error outputs 0.
